// File: rtl/matrix_pkg.sv
// Shared types and constants for the 3x3 matrix-multiply datapath.
package matrix_pkg;
    localparam int MAT_N      = 3;
    localparam int DATA_WIDTH = 8;
    localparam int IDX_WIDTH  = 2;

    localparam logic [IDX_WIDTH-1:0] SLOT_A   = 2'd0;
    localparam logic [IDX_WIDTH-1:0] SLOT_B   = 2'd1;
    localparam logic [IDX_WIDTH-1:0] SLOT_C   = 2'd2;
    localparam logic [IDX_WIDTH-1:0] IDX_LAST = IDX_WIDTH'(MAT_N - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_A,
        ST_RD_B,
        ST_MAC,
        ST_WRITE,
        ST_DONE
    } mm_state_t;
endpackage

// File: rtl/mac_unit.sv
// Single multiply-accumulate lane; the saturated view reflects the value the
// accumulator is about to take, so the final term can be written out without an extra cycle.
module mac_unit import matrix_pkg::*; #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 18
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  accumulate,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] sat_data,
    output logic                  sat_flag
);
    localparam logic [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'({DATA_WIDTH{1'b1}});

    logic [2*DATA_WIDTH-1:0] prod;
    logic [ACC_WIDTH-1:0]    acc_q, acc_d;

    always_comb begin
        prod  = a * b;
        acc_d = acc_q;
        if (clear) begin
            acc_d = '0;
        end else if (accumulate) begin
            acc_d = acc_q + ACC_WIDTH'(prod);
        end
        sat_flag = (acc_d > SAT_MAX);
        sat_data = sat_flag ? {DATA_WIDTH{1'b1}} : acc_d[DATA_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end
endmodule

// File: rtl/matrix_mult_ctrl.sv
// Sequencer that reads A and B from Memory, multiplies them through one MAC lane
// and writes the saturated 3x3 product back into the DST slot.
//
//   state    | meaning
//   IDLE     | waiting for start, memory port quiet
//   RD_A     | address A[i][k]
//   RD_B     | capture A[i][k], address B[k][j]
//   MAC      | acc += A[i][k] * B[k][j]
//   WRITE    | C[i][j] <= sat(acc), advance j/i
//   DONE     | one-cycle completion pulse
module matrix_mult_ctrl import matrix_pkg::*; #(
    parameter int             DATA_WIDTH = 8,
    parameter int             ACC_WIDTH  = 18,
    parameter logic [1:0]     SRC_A      = SLOT_A,
    parameter logic [1:0]     SRC_B      = SLOT_B,
    parameter logic [1:0]     DST        = SLOT_C
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [1:0]            mem_matrix_select,
    output logic [1:0]            mem_row,
    output logic [1:0]            mem_col,
    output logic                  mem_read_enable,
    output logic                  mem_write_enable,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic [DATA_WIDTH-1:0] mem_read_data
);
    generate
        if (DST == SRC_A || DST == SRC_B) begin : g_dst_check
            $error("matrix_mult_ctrl: DST slot must differ from SRC_A and SRC_B");
        end
    endgenerate

    mm_state_t             state_q, state_d;
    logic [IDX_WIDTH-1:0]  i_q, i_d, j_q, j_d, k_q, k_d;
    logic [DATA_WIDTH-1:0] a_op_q, a_op_d;
    logic                  busy_q, busy_d, done_q, done_d, ovf_q, ovf_d;
    logic [1:0]            sel_q, sel_d, row_q, row_d, col_q, col_d;
    logic                  re_q, re_d, we_q, we_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  mac_clear, mac_accum, mac_ovf;
    logic [DATA_WIDTH-1:0] mac_sat;

    mac_unit #(.DATA_WIDTH(DATA_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_mac (
        .clk        (clk),
        .reset      (reset),
        .clear      (mac_clear),
        .accumulate (mac_accum),
        .a          (a_op_q),
        .b          (mem_read_data),
        .sat_data   (mac_sat),
        .sat_flag   (mac_ovf)
    );

    // Outputs are computed for the state being entered so every mem_* pin is a flop.
    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        k_d       = k_q;
        a_op_d    = a_op_q;
        ovf_d     = ovf_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        sel_d     = 2'd0;
        row_d     = 2'd0;
        col_d     = 2'd0;
        re_d      = 1'b0;
        we_d      = 1'b0;
        wdata_d   = '0;
        mac_clear = 1'b0;
        mac_accum = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_RD_A;
                    mac_clear = 1'b1;
                    i_d       = '0;
                    j_d       = '0;
                    k_d       = '0;
                    ovf_d     = 1'b0;
                    busy_d    = 1'b1;
                    sel_d     = SRC_A;
                    re_d      = 1'b1;
                end
            end
            ST_RD_A: begin
                state_d = ST_RD_B;
                busy_d  = 1'b1;
                sel_d   = SRC_B;
                row_d   = k_q;
                col_d   = j_q;
                re_d    = 1'b1;
            end
            ST_RD_B: begin
                state_d = ST_MAC;
                a_op_d  = mem_read_data;
                busy_d  = 1'b1;
            end
            ST_MAC: begin
                mac_accum = 1'b1;
                busy_d    = 1'b1;
                row_d     = i_q;
                if (k_q != IDX_LAST) begin
                    state_d = ST_RD_A;
                    k_d     = k_q + 1'b1;
                    sel_d   = SRC_A;
                    col_d   = k_q + 1'b1;
                    re_d    = 1'b1;
                end else begin
                    state_d = ST_WRITE;
                    sel_d   = DST;
                    col_d   = j_q;
                    we_d    = 1'b1;
                    wdata_d = mac_sat;
                    if (mac_ovf) begin
                        ovf_d = 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                mac_clear = 1'b1;
                k_d       = '0;
                busy_d    = 1'b1;
                if (j_q == IDX_LAST && i_q == IDX_LAST) begin
                    state_d = ST_DONE;
                    j_d     = '0;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_RD_A;
                    sel_d   = SRC_A;
                    re_d    = 1'b1;
                    if (j_q == IDX_LAST) begin
                        j_d   = '0;
                        i_d   = i_q + 1'b1;
                        row_d = i_q + 1'b1;
                    end else begin
                        j_d   = j_q + 1'b1;
                        row_d = i_q;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            a_op_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            sel_q   <= 2'd0;
            row_q   <= 2'd0;
            col_q   <= 2'd0;
            re_q    <= 1'b0;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            a_op_q  <= a_op_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            sel_q   <= sel_d;
            row_q   <= row_d;
            col_q   <= col_d;
            re_q    <= re_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
        end
    end

    assign busy              = busy_q;
    assign done              = done_q;
    assign overflow          = ovf_q;
    assign mem_matrix_select = sel_q;
    assign mem_row           = row_q;
    assign mem_col           = col_q;
    assign mem_read_enable   = re_q;
    assign mem_write_enable  = we_q;
    assign mem_write_data    = wdata_q;
endmodule

// File: tb/tb_matrix_mult_ctrl.sv
// Bench for matrix_mult_ctrl: behavioural Memory, write scoreboard and per-scenario tasks.
module tb_matrix_mult_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       busy, done, overflow;
    logic [1:0] mem_matrix_select, mem_row, mem_col;
    logic       mem_read_enable, mem_write_enable;
    logic [7:0] mem_write_data;
    logic [7:0] mem_read_data = 8'h00;

    matrix_mult_ctrl dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .busy              (busy),
        .done              (done),
        .overflow          (overflow),
        .mem_matrix_select (mem_matrix_select),
        .mem_row           (mem_row),
        .mem_col           (mem_col),
        .mem_read_enable   (mem_read_enable),
        .mem_write_enable  (mem_write_enable),
        .mem_write_data    (mem_write_data),
        .mem_read_data     (mem_read_data)
    );

    always #5 clk = ~clk;

    logic [7:0] ma  [3][3];
    logic [7:0] mb  [3][3];
    logic [7:0] dst [3][3];
    logic       dst_fill = 1'b0;

    always @(posedge clk) begin
        if (dst_fill) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    dst[r][c] <= 8'hAA;
        end else if (mem_write_enable && mem_matrix_select == 2'd2 && mem_row < 2'd3 && mem_col < 2'd3) begin
            dst[mem_row][mem_col] <= mem_write_data;
        end
        if (mem_read_enable) begin
            if (mem_row > 2'd2 || mem_col > 2'd2)
                mem_read_data <= 8'h00;
            else if (mem_matrix_select == 2'd0)
                mem_read_data <= ma[mem_row][mem_col];
            else if (mem_matrix_select == 2'd1)
                mem_read_data <= mb[mem_row][mem_col];
            else if (mem_matrix_select == 2'd2)
                mem_read_data <= dst[mem_row][mem_col];
            else
                mem_read_data <= 8'h00;
        end
    end

    typedef struct {
        logic [1:0] r;
        logic [1:0] c;
        logic [7:0] d;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic exp_ovf  = 1'b0;

    // Scoreboard side: every write must match the next expected element, in order.
    exp_t mon_e;
    always @(negedge clk) begin
        if (reset) begin
            n_checks++;
            if (mem_read_enable && mem_write_enable) begin
                n_fail++;
                $display("FAIL rd_wr_exclusive: read_enable=%0b write_enable=%0b, required not both 1", mem_read_enable, mem_write_enable);
            end
            if (mem_write_enable) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_write: sel=%0d row=%0d col=%0d data=%0d with no write expected", mem_matrix_select, mem_row, mem_col, mem_write_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    if ({mem_matrix_select, mem_row, mem_col, mem_write_data} !== {2'd2, mon_e.r, mon_e.c, mon_e.d}) begin
                        n_fail++;
                        $display("FAIL write_element: got sel=%0d row=%0d col=%0d data=%0d, required sel=2 row=%0d col=%0d data=%0d",
                                 mem_matrix_select, mem_row, mem_col, mem_write_data, mon_e.r, mon_e.c, mon_e.d);
                    end
                end
            end
        end
    end

    task automatic set_mats(input int kind);
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                case (kind)
                    0: begin ma[r][c] = (r == c) ? 8'd1 : 8'd0; mb[r][c] = 8'(r * 3 + c + 1); end
                    1: begin ma[r][c] = 8'd2;   mb[r][c] = 8'd3; end
                    2: begin ma[r][c] = 8'd255; mb[r][c] = 8'd255; end
                    default: begin ma[r][c] = 8'd2; mb[r][c] = 8'(r * 3 + c + 1); end
                endcase
            end
        end
    endtask

    task automatic compute_expected();
        int   s;
        exp_t e;
        exp_ovf = 1'b0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                s = 0;
                for (int k = 0; k < 3; k++)
                    s += int'(ma[r][k]) * int'(mb[k][c]);
                e.r = 2'(r);
                e.c = 2'(c);
                e.d = (s > 255) ? 8'hFF : 8'(s);
                if (s > 255) exp_ovf = 1'b1;
                exp_q.push_back(e);
            end
        end
    endtask

    // Returns the cycle (start edge = cycle 0) at which done is seen, or -1.
    task automatic do_run(input int p1, input int p2, input int rst_cyc, output int done_cyc);
        int cyc;
        done_cyc = -1;
        compute_expected();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_cycle1: busy=%0b, required 1", busy);
        end
        while (cyc < 120) begin
            if (done === 1'b1) begin
                done_cyc = cyc;
                break;
            end
            if (cyc == rst_cyc) begin
                reset = 1'b0;
                exp_q.delete();
                break;
            end
            start = (cyc == p1 || cyc == p2);
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({busy, done, overflow, mem_read_enable, mem_write_enable} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: busy/done/ovf/re/we=%b, required 00000", {busy, done, overflow, mem_read_enable, mem_write_enable});
        end
        n_checks++;
        if ({mem_matrix_select, mem_row, mem_col, mem_write_data} !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_mem_bus: sel/row/col/data=%h, required 0", {mem_matrix_select, mem_row, mem_col, mem_write_data});
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({busy, mem_read_enable, mem_write_enable, mem_matrix_select, mem_row, mem_col} !== 9'd0) begin
            n_fail++;
            $display("FAIL idle_quiet: busy/re/we/sel/row/col=%b, required 0", {busy, mem_read_enable, mem_write_enable, mem_matrix_select, mem_row, mem_col});
        end
    endtask

    task automatic test_identity();
        int dc;
        set_mats(0);
        do_run(-1, -1, -1, dc);
        n_checks++;
        if (dc !== 91) begin
            n_fail++;
            $display("FAIL identity_done_cycle: done at cycle %0d, required 91", dc);
        end
        n_checks++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL identity_overflow: overflow=%0b, required 0", overflow);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({busy, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL identity_after_done: busy/done=%b, required 00", {busy, done});
        end
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                n_checks++;
                if (dst[r][c] !== 8'(r * 3 + c + 1)) begin
                    n_fail++;
                    $display("FAIL identity_dst[%0d][%0d]: got %0d, required %0d", r, c, dst[r][c], r * 3 + c + 1);
                end
            end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL identity_writes: %0d expected writes missing, required 0", exp_q.size());
        end
    endtask

    task automatic test_const();
        int dc;
        set_mats(1);
        do_run(-1, -1, -1, dc);
        n_checks++;
        if (dc !== 91 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL const_run: done cycle %0d overflow %0b, required 91 and 0", dc, overflow);
        end
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                n_checks++;
                if (dst[r][c] !== 8'd18) begin
                    n_fail++;
                    $display("FAIL const_dst[%0d][%0d]: got %0d, required 18", r, c, dst[r][c]);
                end
            end
        @(posedge clk); #1;
    endtask

    task automatic test_saturate();
        int dc;
        set_mats(2);
        do_run(-1, -1, -1, dc);
        n_checks++;
        if (dc !== 91 || overflow !== 1'b1 || overflow !== exp_ovf) begin
            n_fail++;
            $display("FAIL saturate_run: done cycle %0d overflow %0b, required 91 and 1", dc, overflow);
        end
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                n_checks++;
                if (dst[r][c] !== 8'd255) begin
                    n_fail++;
                    $display("FAIL saturate_dst[%0d][%0d]: got %0d, required 255", r, c, dst[r][c]);
                end
            end
        repeat (6) @(posedge clk);
        #1;
        n_checks++;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_sticky: overflow=%0b after idle, required 1", overflow);
        end
    endtask

    task automatic test_start_ignored();
        int dc;
        int exp_v;
        set_mats(3);
        do_run(10, 50, -1, dc);
        n_checks++;
        if (dc !== 91) begin
            n_fail++;
            $display("FAIL restart_done_cycle: done at cycle %0d, required 91", dc);
        end
        n_checks++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_overflow: overflow=%0b, required 0", overflow);
        end
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                exp_v = 2 * (12 + 3 * c);
                n_checks++;
                if (dst[r][c] !== 8'(exp_v)) begin
                    n_fail++;
                    $display("FAIL restart_dst[%0d][%0d]: got %0d, required %0d", r, c, dst[r][c], exp_v);
                end
            end
        @(posedge clk); #1;
        n_checks++;
        if ({busy, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL restart_idle: busy/done=%b, required 00", {busy, done});
        end
    endtask

    task automatic test_reset_midrun();
        int dc;
        @(negedge clk);
        dst_fill = 1'b1;
        @(negedge clk);
        dst_fill = 1'b0;
        set_mats(2);
        do_run(-1, -1, 40, dc);
        #1;
        n_checks++;
        if ({busy, done, overflow, mem_read_enable, mem_write_enable, mem_matrix_select, mem_row, mem_col, mem_write_data} !== 19'd0) begin
            n_fail++;
            $display("FAIL midrun_reset_outputs: busy/done/ovf=%b%b%b re/we=%b%b data=%0d, required all 0", busy, done, overflow, mem_read_enable, mem_write_enable, mem_write_data);
        end
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({busy, overflow, mem_write_enable, mem_read_enable} !== 4'd0) begin
            n_fail++;
            $display("FAIL midrun_reset_held: busy/ovf/we/re=%b, required 0000", {busy, overflow, mem_write_enable, mem_read_enable});
        end
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                n_checks++;
                if (dst[r][c] !== ((r == 0) ? 8'd255 : 8'hAA)) begin
                    n_fail++;
                    $display("FAIL midrun_partial_dst[%0d][%0d]: got %0d, required %0d", r, c, dst[r][c], (r == 0) ? 255 : 170);
                end
            end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        set_mats(0);
        do_run(-1, -1, -1, dc);
        n_checks++;
        if (dc !== 91 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_run: done cycle %0d overflow %0b, required 91 and 0", dc, overflow);
        end
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                n_checks++;
                if (dst[r][c] !== 8'(r * 3 + c + 1)) begin
                    n_fail++;
                    $display("FAIL post_reset_dst[%0d][%0d]: got %0d, required %0d", r, c, dst[r][c], r * 3 + c + 1);
                end
            end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int dc1;
        int dc2;
        set_mats(2);
        do_run(-1, -1, -1, dc1);
        n_checks++;
        if (dc1 !== 91 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_first: done cycle %0d overflow %0b, required 91 and 1", dc1, overflow);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({busy, done, overflow} !== 3'b001) begin
            n_fail++;
            $display("FAIL b2b_gap: busy/done/ovf=%b, required 001", {busy, done, overflow});
        end
        set_mats(0);
        do_run(-1, -1, -1, dc2);
        n_checks++;
        if (dc2 !== 91 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_second: done cycle %0d overflow %0b, required 91 and 0", dc2, overflow);
        end
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                n_checks++;
                if (dst[r][c] !== 8'(r * 3 + c + 1)) begin
                    n_fail++;
                    $display("FAIL b2b_dst[%0d][%0d]: got %0d, required %0d", r, c, dst[r][c], r * 3 + c + 1);
                end
            end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_writes: %0d expected writes missing, required 0", exp_q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_identity();
        test_const();
        test_saturate();
        test_start_ignored();
        test_reset_midrun();
        test_back_to_back();
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
